// File: rtl/inst_decode.sv
// -----------------------------------------------------------------------------
// inst_decode
// RV32I instruction decoder with a two-entry output buffer (main + skid).
// The word is decoded combinationally and the decoded entry is captured into
// the main register, or into the skid register when the main entry is stalled.
//
// Optional feature macro: ILLEGAL_INSN_EN
//   defined   -> illegal=1 for unknown opcodes and undefined OP/OP-IMM
//                funct3/funct7 combinations (all enables 0)
//   undefined -> illegal tied to 0; such entries pass through as no-ops
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   in_valid/in_ready      upstream handshake (in_ready = skid empty, registered)
//   in_instr, in_pc        instruction word and its address
//   flush                  drop every held entry and any same-cycle accept
//   out_valid/out_ready    downstream handshake
//   out_pc                 PC of the presented entry
//   alu_opcode, funct      ALU control encoding
//   rd, rs1, rs2, imm      register fields and sign-extended immediate
//   reg_write, mem_read, mem_write, branch, alu_src   control enables
//   illegal                illegal-instruction flag
// -----------------------------------------------------------------------------
module inst_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [1:0]  alu_opcode,
    output logic [3:0]  funct,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        alu_src,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  alu_opcode;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        alu_src;
        logic        illegal;
    } entry_t;

    // OP allows funct7=0100000 only for SUB/SRA; OP-IMM constrains the shifts.
    function automatic logic funct_ok(input logic [6:0] opc,
                                      input logic [2:0] f3,
                                      input logic [6:0] f7);
        logic ok;
        ok = 1'b1;
        if (opc == OPC_OP) begin
            ok = (f7 == 7'b0000000) ||
                 ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        end else if (opc == OPC_OPIMM) begin
            if (f3 == 3'b001) begin
                ok = (f7 == 7'b0000000);
            end else if (f3 == 3'b101) begin
                ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            end else begin
                ok = 1'b1;
            end
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    logic [6:0]  opc_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic        known_s;
    entry_t      dec_s;

    entry_t      main_r, skid_r, main_n_s, skid_n_s;
    logic        main_valid_r, skid_valid_r, in_ready_r;
    logic        main_valid_n_s, skid_valid_n_s;
    logic        accept_s, pop_s;

    assign opc_s   = in_instr[6:0];
    assign imm_i_s = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u_s = {in_instr[31:12], 12'h000};
    assign imm_j_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};

    // Combinational decode of the incoming word into an entry.
    always_comb begin
        dec_s     = '0;
        known_s   = 1'b1;
        dec_s.pc  = in_pc;
        dec_s.rd  = in_instr[11:7];
        dec_s.rs1 = in_instr[19:15];
        dec_s.rs2 = in_instr[24:20];
        case (opc_s)
            OPC_OP: begin
                dec_s.alu_opcode = 2'b10;
                dec_s.funct      = {in_instr[30], in_instr[14:12]};
                dec_s.reg_write  = 1'b1;
            end
            OPC_OPIMM: begin
                dec_s.funct     = {in_instr[30], in_instr[14:12]};
                dec_s.reg_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.imm       = imm_i_s;
            end
            OPC_LOAD: begin
                dec_s.alu_opcode = 2'b01;
                dec_s.mem_read   = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.alu_src    = 1'b1;
                dec_s.imm        = imm_i_s;
            end
            OPC_STORE: begin
                dec_s.alu_opcode = 2'b01;
                dec_s.mem_write  = 1'b1;
                dec_s.alu_src    = 1'b1;
                dec_s.imm        = imm_s_s;
            end
            OPC_BRANCH: begin
                dec_s.alu_opcode = 2'b10;
                dec_s.funct      = 4'b1000;
                dec_s.branch     = 1'b1;
                dec_s.imm        = imm_b_s;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                dec_s.alu_opcode = 2'b01;
                dec_s.reg_write  = 1'b1;
                dec_s.alu_src    = 1'b1;
                if ((opc_s == OPC_LUI) || (opc_s == OPC_AUIPC)) begin
                    dec_s.imm = imm_u_s;
                end else if (opc_s == OPC_JAL) begin
                    dec_s.imm = imm_j_s;
                end else begin
                    dec_s.imm = imm_i_s;
                end
            end
            default: begin
                known_s = 1'b0;
            end
        endcase
        // Undecodable entries become no-ops: all control and ALU fields zero.
        if (!known_s || !funct_ok(opc_s, in_instr[14:12], in_instr[31:25])) begin
            dec_s.alu_opcode = 2'b00;
            dec_s.funct      = 4'b0000;
            dec_s.imm        = 32'h0000_0000;
            dec_s.reg_write  = 1'b0;
            dec_s.mem_read   = 1'b0;
            dec_s.mem_write  = 1'b0;
            dec_s.branch     = 1'b0;
            dec_s.alu_src    = 1'b0;
`ifdef ILLEGAL_INSN_EN
            dec_s.illegal    = 1'b1;
`else
            dec_s.illegal    = 1'b0;
`endif
        end else begin
            dec_s.illegal    = 1'b0;
        end
    end

    assign accept_s = in_valid & in_ready_r & ~flush;
    assign pop_s    = main_valid_r & out_ready;

    // Next-state of the main/skid pair. An accept implies the skid is empty
    // (in_ready mirrors it), so a skid->main move and an accept never collide.
    always_comb begin
        main_n_s       = main_r;
        skid_n_s       = skid_r;
        main_valid_n_s = main_valid_r;
        skid_valid_n_s = skid_valid_r;
        if (flush) begin
            main_valid_n_s = 1'b0;
            skid_valid_n_s = 1'b0;
        end else begin
            if (pop_s) begin
                if (skid_valid_r) begin
                    main_n_s       = skid_r;
                    main_valid_n_s = 1'b1;
                    skid_valid_n_s = 1'b0;
                end else begin
                    main_valid_n_s = 1'b0;
                end
            end else begin
                main_valid_n_s = main_valid_r;
            end
            if (accept_s) begin
                if (!main_valid_r || out_ready) begin
                    main_n_s       = dec_s;
                    main_valid_n_s = 1'b1;
                end else begin
                    skid_n_s       = dec_s;
                    skid_valid_n_s = 1'b1;
                end
            end else begin
                skid_n_s = skid_n_s;
            end
        end
    end

    // Buffer registers and the registered in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_r       <= '0;
            skid_r       <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            main_r       <= main_n_s;
            skid_r       <= skid_n_s;
            main_valid_r <= main_valid_n_s;
            skid_valid_r <= skid_valid_n_s;
            in_ready_r   <= ~skid_valid_n_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = main_valid_r;
    assign out_pc     = main_r.pc;
    assign alu_opcode = main_r.alu_opcode;
    assign funct      = main_r.funct;
    assign rd         = main_r.rd;
    assign rs1        = main_r.rs1;
    assign rs2        = main_r.rs2;
    assign imm        = main_r.imm;
    assign reg_write  = main_r.reg_write;
    assign mem_read   = main_r.mem_read;
    assign mem_write  = main_r.mem_write;
    assign branch     = main_r.branch;
    assign alu_src    = main_r.alu_src;
    assign illegal    = main_r.illegal;

endmodule

// File: doc/inst_decode.md
INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have ports in_valid (input, 1), in_ready (output, 1): upstream handshake.
REQ-004 SHALL have ports in_instr (input, 32) and in_pc (input, 32): RV32I instruction word and its address.
REQ-005 SHALL have port flush, input, 1: discard all held entries.
REQ-006 SHALL have ports out_valid (output, 1), out_ready (input, 1): downstream handshake.
REQ-007 SHALL have port out_pc, output, 32: PC of the presented entry.
REQ-008 SHALL have ports alu_opcode (output, 2) and funct (output, 4): ALU-control encoding.
REQ-009 SHALL have ports rd, rs1, rs2 (output, 5 each) and imm (output, 32, sign-extended).
REQ-010 SHALL have ports reg_write, mem_read, mem_write, branch, alu_src (output, 1 each).
REQ-011 SHALL have port illegal, output, 1 (see Configuration).

Function
REQ-012 SHALL decode opcode 0110011 (OP) as alu_opcode=10, funct={instr[30],instr[14:12]}, reg_write=1, alu_src=0.
REQ-013 SHALL decode 0010011 (OP-IMM) as alu_opcode=00, funct={instr[30],instr[14:12]}, reg_write=1, alu_src=1, I-immediate.
REQ-014 SHALL decode 0000011 (LOAD) as alu_opcode=01, mem_read=1, reg_write=1, alu_src=1, I-immediate.
REQ-015 SHALL decode 0100011 (STORE) as alu_opcode=01, mem_write=1, alu_src=1, S-immediate.
REQ-016 SHALL decode 1100011 (BRANCH) as alu_opcode=10, funct=1000, branch=1, alu_src=0, B-immediate.
REQ-017 SHALL decode LUI/AUIPC/JAL/JALR as alu_opcode=01, reg_write=1, alu_src=1, U/U/J/I immediate respectively.
REQ-018 SHALL set funct=0000 and imm=0 where a format defines no such field; unknown opcodes SHALL drive all enables 0.
REQ-019 SHALL buffer entries in a main register plus one skid register; decode is combinational before capture.
REQ-020 SHALL drive in_ready registered, equal to "skid register empty".
REQ-021 SHALL, on accept (in_valid & in_ready): load main if main empty or out_ready, else load skid.
REQ-022 SHALL, on out_valid & out_ready with skid full, move skid into main and empty skid in the same edge.
REQ-023 SHALL present a newly accepted entry on outputs exactly one cycle after acceptance (latency 1).
REQ-024 SHALL keep all outputs stable while out_valid=1 and out_ready=0.
REQ-025 SHALL preserve program order; skid entry never overtakes main.
REQ-026 SHALL, on flush=1, empty both registers at that edge, discard any same-cycle accept, and set in_ready=1.
REQ-027 SHALL hold out_valid=0 for at least the cycle following a flush.

Reset
REQ-028 SHALL, on rst=1, immediately clear out_valid, all enables, illegal, alu_opcode, funct, rd, rs1, rs2, imm, out_pc to 0.
REQ-029 SHALL drive in_ready=1 during and after reset.
REQ-030 SHALL abandon any held entries when reset asserts mid-stream; first post-reset accept is the next entry presented.

Configuration
REQ-031 SHALL, with ILLEGAL_INSN_EN defined, assert illegal=1 with the entry for an unknown opcode or an undefined funct3/funct7 combination in OP/OP-IMM, all enables 0.
REQ-032 SHALL, without ILLEGAL_INSN_EN, tie illegal to 0 and decode such entries as no-ops (enables 0).

Verification
REQ-033 SHALL cover: reset, then instr 0x40B50533 (sub x10,x10,x11), out_ready=1 -> next cycle out_valid=1, alu_opcode=10, funct=1000, rd=10, reg_write=1.
REQ-034 SHALL cover: instr 0xFFC12083 (lw x1,-4(x2)) -> alu_opcode=01, imm=0xFFFFFFFC, mem_read=1, alu_src=1.
REQ-035 SHALL cover: out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 after second, outputs stable; out_ready=1 -> drained in order.
REQ-036 SHALL cover: flush with both registers full and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed entries never appear.
REQ-037 SHALL cover: instr 0xFFFFFFFF with ILLEGAL_INSN_EN -> illegal=1, enables 0; without -> illegal=0, enables 0.
REQ-038 SHALL cover: rst pulse mid-stream, unaligned to clk -> outputs 0 immediately, in_ready=1.
